// File: rtl/ucode_store_pkg.sv
// Shared definitions for the microcode control store: default geometry,
// the NOP microinstruction, loader FSM encoding and byte-lane positions.
package ucode_store_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 24;

  // ALU op 111, no register enables, uPC hold
  localparam logic [23:0] NOP_WORD_DEF = 24'hE00000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BYTE0 = 3'd1;
  localparam logic [2:0] ST_BYTE1 = 3'd2;
  localparam logic [2:0] ST_BYTE2 = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Bytes arrive least significant first
  localparam int LANE_W = 8;
  localparam int LANE0  = 0;
  localparam int LANE1  = 1;
  localparam int LANE2  = 2;

  // True in the states where the loader accepts a byte
  function automatic logic is_byte_state(input logic [2:0] st);
    return (st == ST_BYTE0) || (st == ST_BYTE1) || (st == ST_BYTE2);
  endfunction

endpackage

// File: rtl/ucode_ram.sv
// Control-store array: one synchronous write port and one synchronous,
// enable-gated read port. Contents are never reset.
module ucode_ram #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Loader writes one assembled word per write strobe
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data only changes on a fetch, so it holds between fetches
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ucode_store.sv
// Microcode control store: answers sequencer fetches from the RAM and runs
// a byte-serial valid/ready loader that writes microprograms at run time.
// While a load session is active every fetch returns the NOP word.
module ucode_store #(
  parameter int            AW       = ucode_store_pkg::AW_DEF,
  parameter int            DW       = ucode_store_pkg::DW_DEF,
  parameter logic [DW-1:0] NOP_WORD = ucode_store_pkg::NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_len,
  input  logic [7:0]    ld_byte,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_abort,
  output logic          ld_done,
  output logic          busy
);

  import ucode_store_pkg::*;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] asm_q, asm_d;
  logic          sel_ram_q;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  assign busy     = (state_q != ST_IDLE);
  assign ld_ready = is_byte_state(state_q);
  assign ld_done  = (state_q == ST_DONE);

  // Abort wins over a write in the same cycle, so nothing lands in memory
  assign ram_we = (state_q == ST_WRITE) && !ld_abort;

  ucode_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ptr_q),
    .wdata(asm_q),
    .re   (rd_en && !busy),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  // Loader sequencing: capture session, assemble three bytes, write, repeat
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    asm_d   = asm_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          rem_d   = ld_len;
          asm_d   = '0;
          state_d = (ld_len == '0) ? ST_DONE : ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        if (ld_abort) begin
          state_d = ST_IDLE;
          asm_d   = '0;
        end else if (ld_valid) begin
          asm_d[LANE0*LANE_W +: LANE_W] = ld_byte;
          state_d = ST_BYTE1;
        end
      end
      ST_BYTE1: begin
        if (ld_abort) begin
          state_d = ST_IDLE;
          asm_d   = '0;
        end else if (ld_valid) begin
          asm_d[LANE1*LANE_W +: LANE_W] = ld_byte;
          state_d = ST_BYTE2;
        end
      end
      ST_BYTE2: begin
        if (ld_abort) begin
          state_d = ST_IDLE;
          asm_d   = '0;
        end else if (ld_valid) begin
          asm_d[LANE2*LANE_W +: LANE_W] = ld_byte;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ld_abort) begin
          state_d = ST_IDLE;
          asm_d   = '0;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == (AW+1)'(1)) ? ST_DONE : ST_BYTE0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      asm_q   <= asm_d;
    end
  end

  // Remember whether the last fetch came from RAM or was forced to NOP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_ram_q <= 1'b0;
    end else if (rd_en) begin
      sel_ram_q <= !busy;
    end
  end

  assign rd_data = sel_ram_q ? ram_rdata : NOP_WORD;

endmodule

// File: tb/tb_ucode_store.sv
// Randomized scoreboard bench for the microcode control store.
// The driver pushes the expected fetch result when it issues a fetch;
// a separate monitor pops and compares once the result is presented.
module tb_ucode_store;

  localparam logic [23:0] NOP = 24'hE00000;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic [8:0]  ld_len;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_abort;
  logic        ld_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] memModel [256];
  logic [23:0] wordBuf  [256];
  logic [23:0] expQ [$];
  logic        fetchFlag;

  ucode_store dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_len  (ld_len),
    .ld_byte (ld_byte),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_abort(ld_abort),
    .ld_done (ld_done),
    .busy    (busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare a 24-bit value
  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare a single flag
  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Note which edges carried a fetch so the monitor knows when data is due
  always @(posedge clk or negedge rst) begin
    if (!rst) fetchFlag <= 1'b0;
    else      fetchFlag <= rd_en;
  end

  // Scoreboard monitor: compare fetch results away from the active edge
  always @(negedge clk) begin
    if (fetchFlag) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_data: got %h with no expected entry queued", rd_data);
      end else begin
        checkOutput("rd_data", rd_data, expQ.pop_front());
      end
    end
  end

  // Fetch one known address while idle; expectation comes from the model
  task automatic fetchWord(input logic [7:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    expQ.push_back(memModel[a]);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // Run one load session of len words from wordBuf starting at base.
  // gap: 0 valid always, 1 valid every other cycle, 2 random valid.
  // interruptAt >= 0 aborts (or resets) once that many bytes have moved.
  task automatic applyStimulus(input logic [7:0] base, input int len, input int gap,
                               input int interruptAt, input bit interruptReset,
                               input bit fetchDuring);
    int sent;
    int cycles;
    int total;
    bit writePend;
    logic [7:0]  addr;
    logic [23:0] cur;
    sent      = 0;
    cycles    = 0;
    total     = 3 * len;
    writePend = 1'b0;
    addr      = base;
    cur       = '0;

    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = 9'(len);
    ld_abort = 1'($urandom_range(0, 1));
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    @(posedge clk); #1;
    ld_start = 1'b0;
    ld_abort = 1'b0;

    while ((sent < total || writePend) && cycles < 20000) begin
      cycles++;
      checkFlag("busy during load", busy, 1'b1);
      checkFlag("ld_ready", ld_ready, !writePend);
      checkFlag("ld_done during load", ld_done, 1'b0);

      if (interruptAt >= 0 && sent == interruptAt && !writePend) begin
        if (interruptReset) begin
          ld_valid = 1'b0;
          rd_en    = 1'b0;
          #2 rst = 1'b0;
          #1;
          checkFlag("reset busy", busy, 1'b0);
          checkFlag("reset ld_ready", ld_ready, 1'b0);
          checkFlag("reset ld_done", ld_done, 1'b0);
          checkOutput("reset rd_data", rd_data, NOP);
          #3 rst = 1'b1;
          @(posedge clk); #1;
          checkFlag("after reset busy", busy, 1'b0);
        end else begin
          ld_abort = 1'b1;
          ld_valid = 1'b1;
          ld_byte  = 8'($urandom);
          rd_en    = 1'b0;
          @(posedge clk); #1;
          ld_abort = 1'b0;
          ld_valid = 1'b0;
          checkFlag("abort busy", busy, 1'b0);
          checkFlag("abort ld_done", ld_done, 1'b0);
          checkFlag("abort ld_ready", ld_ready, 1'b0);
        end
        return;
      end

      if (writePend)     ld_valid = 1'($urandom_range(0, 1));
      else if (gap == 0) ld_valid = 1'b1;
      else if (gap == 1) ld_valid = cycles[0];
      else               ld_valid = 1'($urandom_range(0, 1));
      if (ld_valid && !writePend) ld_byte = wordBuf[sent / 3][8 * (sent % 3) +: 8];
      else                        ld_byte = 8'($urandom);

      ld_start = ($urandom_range(0, 7) == 0);
      ld_base  = 8'($urandom);
      ld_len   = 9'($urandom_range(0, 256));

      if (fetchDuring) begin
        rd_en   = 1'($urandom_range(0, 1));
        rd_addr = 8'($urandom);
        if (rd_en) expQ.push_back(NOP);
      end else begin
        rd_en = 1'b0;
      end

      @(posedge clk); #1;
      if (writePend) begin
        memModel[addr] = cur;
        addr           = addr + 8'd1;
        writePend      = 1'b0;
      end else if (ld_valid) begin
        cur[8 * (sent % 3) +: 8] = ld_byte;
        sent++;
        if (sent % 3 == 0) writePend = 1'b1;
      end
    end

    ld_start = 1'b0;
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    if (cycles >= 20000) begin
      checks++;
      errors++;
      $display("[TB] FAIL load timeout: got %0d bytes expected %0d", sent, total);
      return;
    end

    checkFlag("ld_done pulse", ld_done, 1'b1);
    checkFlag("busy in final cycle", busy, 1'b1);
    checkFlag("ld_ready in final cycle", ld_ready, 1'b0);
    if (fetchDuring) begin
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 8'($urandom);
      if (rd_en) expQ.push_back(NOP);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    checkFlag("ld_done after session", ld_done, 1'b0);
    checkFlag("busy after session", busy, 1'b0);
  endtask

  // Main sequence
  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int n;
    rst      = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_len   = '0;
    ld_byte  = '0;
    ld_valid = 1'b0;
    ld_abort = 1'b0;
    #12;
    checkOutput("reset rd_data", rd_data, NOP);
    checkFlag("reset busy", busy, 1'b0);
    checkFlag("reset ld_ready", ld_ready, 1'b0);
    checkFlag("reset ld_done", ld_done, 1'b0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle rd_data", rd_data, NOP);

    // Single word, valid held high, fetches issued while busy
    wordBuf[0] = 24'h912803;
    applyStimulus(8'h10, 1, 0, -1, 1'b0, 1'b1);
    fetchWord(8'h10);

    // Same word with gapped valid at a different address
    applyStimulus(8'h20, 1, 1, -1, 1'b0, 1'b1);
    fetchWord(8'h20);

    // Wrap-around from the top of the store
    wordBuf[0] = 24'hAAAAAA;
    wordBuf[1] = 24'h555555;
    applyStimulus(8'hFF, 2, 2, -1, 1'b0, 1'b0);
    fetchWord(8'hFF);
    fetchWord(8'h00);

    // Zero-length session leaves memory alone
    applyStimulus(8'h10, 0, 0, -1, 1'b0, 1'b1);
    fetchWord(8'h10);
    fetchWord(8'hFF);

    // Prefill then abort partway into the second word
    for (int i = 0; i < 3; i++) wordBuf[i] = 24'($urandom);
    applyStimulus(8'h30, 3, 2, -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) wordBuf[i] = 24'($urandom);
    applyStimulus(8'h30, 3, 0, 4, 1'b0, 1'b1);
    fetchWord(8'h30);
    fetchWord(8'h31);
    fetchWord(8'h32);

    // Read data holds while no fetch is issued
    fetchWord(8'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rd_data hold", rd_data, memModel[8'h10]);

    // Asynchronous reset in the middle of a word
    wordBuf[0] = 24'h123456;
    applyStimulus(8'h50, 1, 0, 1, 1'b1, 1'b0);
    fetchWord(8'h10);
    fetchWord(8'h31);

    // Full-store load
    for (int i = 0; i < 256; i++) wordBuf[i] = 24'($urandom);
    b = 8'($urandom);
    applyStimulus(b, 256, 2, -1, 1'b0, 1'b1);
    a = 8'h00;
    for (int i = 0; i < 256; i++) begin
      fetchWord(a);
      a = a + 8'd1;
    end

    // Short randomized sessions
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wordBuf[i] = 24'($urandom);
      b = 8'($urandom);
      applyStimulus(b, n, $urandom_range(0, 2), -1, 1'b0, 1'($urandom_range(0, 1)));
      a = b;
      for (int i = 0; i < n; i++) begin
        fetchWord(a);
        a = a + 8'd1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
